// File: rtl/dmem_access.sv
// Byte-addressable data memory port: word/half/byte loads and stores,
// alignment checking with sticky error capture, 1-cycle load latency.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   Digit           access width (00 word, 01 half, 10 byte, 11 invalid)
//   MemRead         load request
//   MemWrite        store request
//   Addr            byte address
//   WData           right-aligned store data
//   ErrClr          clear sticky alignment error
//   RData           right-aligned, zero-extended load data
//   RValid          one-cycle pulse with each load result
//   AlignErr        sticky misaligned/invalid access flag
//   ErrAddr         address of first error since last clear
module dmem_access #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  Digit,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        ErrClr,
  output logic [31:0] RData,
  output logic        RValid,
  output logic        AlignErr,
  output logic [31:0] ErrAddr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             legal;
  logic             illegal;
  logic [3:0]       be;
  logic [31:0]      wd;
  logic [31:0]      cur;
  logic [31:0]      merged;
  logic [31:0]      rd_sel;

  assign idx     = Addr[IDX_W+1:2];
  assign lane    = Addr[1:0];
  assign cur     = mem[idx];
  assign illegal = (MemRead | MemWrite) & ~legal;

  always_comb begin
    legal = 1'b0;
    case (Digit)
      2'b00:   legal = (lane == 2'b00);
      2'b01:   legal = ~Addr[0];
      2'b10:   legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Lane enables and replicated store data; only a legal store
  // enables any lane, so the merged word doubles as the read path.
  always_comb begin
    be = 4'b0000;
    wd = 32'h0;
    case (Digit)
      2'b00: begin
        be = 4'b1111;
        wd = WData;
      end
      2'b01: begin
        be = Addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{WData[15:0]}};
      end
      2'b10: begin
        be = 4'b0001 << lane;
        wd = {4{WData[7:0]}};
      end
      default: begin
        be = 4'b0000;
        wd = 32'h0;
      end
    endcase
    if (!(MemWrite && legal))
      be = 4'b0000;
  end

  always_comb begin
    merged = cur;
    for (int k = 0; k < 4; k++)
      if (be[k])
        merged[8*k +: 8] = wd[8*k +: 8];
  end

  always_comb begin
    rd_sel = 32'h0;
    case (Digit)
      2'b00:
        rd_sel = merged;
      2'b01:
        rd_sel = {16'h0, Addr[1] ? merged[31:16] : merged[15:0]};
      2'b10:
        rd_sel = {24'h0, merged[{lane, 3'b000} +: 8]};
      default:
        rd_sel = 32'h0;
    endcase
    if (!legal)
      rd_sel = 32'h0;
  end

  // Array is not reset; stores in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && MemWrite && legal)
      mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RData  <= 32'h0;
      RValid <= 1'b0;
    end else begin
      RValid <= MemRead;
      if (MemRead)
        RData <= rd_sel;
    end
  end

  // A new error in the same cycle as ErrClr takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      AlignErr <= 1'b0;
      ErrAddr  <= 32'h0;
    end else if (illegal) begin
      AlignErr <= 1'b1;
      if (!AlignErr || ErrClr)
        ErrAddr <= Addr;
    end else if (ErrClr) begin
      AlignErr <= 1'b0;
      ErrAddr  <= 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// Directed testbench for dmem_access: loads/stores of each width,
// alignment errors, write-first merge, reset behaviour and wrap.
module tb_dmem_access;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic [1:0]  Digit;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        ErrClr;
  logic [31:0] RData;
  logic        RValid;
  logic        AlignErr;
  logic [31:0] ErrAddr;

  int n_vec;
  int n_err;

  dmem_access #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Digit(Digit),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .Addr(Addr),
    .WData(WData),
    .ErrClr(ErrClr),
    .RData(RData),
    .RValid(RValid),
    .AlignErr(AlignErr),
    .ErrAddr(ErrAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, then sample 1ns after the edge.
  task automatic acc(input logic rd, input logic wr,
                     input logic [1:0] dig, input logic [31:0] a,
                     input logic [31:0] wdat, input logic clr);
    MemRead  = rd;
    MemWrite = wr;
    Digit    = dig;
    Addr     = a;
    WData    = wdat;
    ErrClr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    idle();
    check("rst_rdata", RData, 32'h0);
    check("rst_rvalid", {31'h0, RValid}, 32'h0);
    check("rst_alignerr", {31'h0, AlignErr}, 32'h0);
    check("rst_erraddr", ErrAddr, 32'h0);

    acc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    check("rst_load_drop", {31'h0, RValid}, 32'h0);

    rst_n = 1'b1;
    acc(1'b0, 1'b1, 2'b00, 32'h10, 32'h11223344, 1'b0);
    check("store_no_rvalid", {31'h0, RValid}, 32'h0);

    acc(1'b1, 1'b0, 2'b10, 32'h11, 32'h0, 1'b0);
    check("ldb_11", RData, 32'h33);
    check("ldb_11_v", {31'h0, RValid}, 32'h1);
    acc(1'b1, 1'b0, 2'b10, 32'h12, 32'h0, 1'b0);
    check("ldb_12", RData, 32'h22);
    acc(1'b1, 1'b0, 2'b10, 32'h13, 32'h0, 1'b0);
    check("ldb_13", RData, 32'h11);
    check("ldb_13_v", {31'h0, RValid}, 32'h1);
    idle();
    check("idle_rvalid", {31'h0, RValid}, 32'h0);
    check("idle_hold", RData, 32'h11);

    acc(1'b0, 1'b1, 2'b01, 32'h12, 32'h0000BEEF, 1'b0);
    acc(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    check("ldw_half_merge", RData, 32'hBEEF3344);
    acc(1'b1, 1'b0, 2'b01, 32'h12, 32'h0, 1'b0);
    check("ldh_12", RData, 32'h0000BEEF);
    acc(1'b1, 1'b0, 2'b01, 32'h10, 32'h0, 1'b0);
    check("ldh_10", RData, 32'h00003344);

    acc(1'b0, 1'b1, 2'b00, 32'h10, 32'h11223344, 1'b0);
    acc(1'b0, 1'b1, 2'b00, 32'h20, 32'hCAFEF00D, 1'b0);
    check("no_err_yet", {31'h0, AlignErr}, 32'h0);
    acc(1'b0, 1'b1, 2'b00, 32'h21, 32'hDEADBEEF, 1'b0);
    check("mis_st_err", {31'h0, AlignErr}, 32'h1);
    check("mis_st_addr", ErrAddr, 32'h21);
    acc(1'b1, 1'b0, 2'b01, 32'h33, 32'h0, 1'b0);
    check("mis_ld_rdata", RData, 32'h0);
    check("mis_ld_rvalid", {31'h0, RValid}, 32'h1);
    check("mis_ld_keep", ErrAddr, 32'h21);
    acc(1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 1'b0);
    check("mis_st_unchg", RData, 32'hCAFEF00D);

    acc(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 1'b1);
    check("clr_win_err", {31'h0, AlignErr}, 32'h1);
    check("clr_win_addr", ErrAddr, 32'h40);
    check("dig11_rdata", RData, 32'h0);
    acc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    check("clr_err", {31'h0, AlignErr}, 32'h0);
    check("clr_addr", ErrAddr, 32'h0);
    acc(1'b0, 1'b0, 2'b11, 32'h41, 32'h0, 1'b0);
    check("noreq_noerr", {31'h0, AlignErr}, 32'h0);

    acc(1'b1, 1'b1, 2'b10, 32'h10, 32'h000000AA, 1'b0);
    check("rw_merge", RData, 32'h000000AA);
    acc(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    check("rw_word", RData, 32'h112233AA);

    acc(1'b0, 1'b1, 2'b10, 32'h1E, 32'h0000005A, 1'b0);
    acc(1'b0, 1'b1, 2'b10, 32'h1F, 32'h000000C3, 1'b0);
    acc(1'b1, 1'b0, 2'b01, 32'h1E, 32'h0, 1'b0);
    check("byte_lanes", RData, 32'h0000C35A);

    rst_n = 1'b0;
    acc(1'b0, 1'b1, 2'b00, 32'h10, 32'h99999999, 1'b0);
    check("rst_rdata2", RData, 32'h0);
    rst_n = 1'b1;
    acc(1'b1, 1'b0, 2'b00, DEPTH * 4 + 32'h10, 32'h0, 1'b0);
    check("wrap_rst_store", RData, 32'h112233AA);
    check("wrap_rvalid", {31'h0, RValid}, 32'h1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
